// File: rtl/cd_spi_pkg.sv
// Shared definitions for the SPI-to-CSR bridge: FSM encoding, header
// field positions and the default synchronizer depth.
package cd_spi_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // Header byte layout: bit 7 selects write, bits 4:0 carry the address.
    localparam int HDR_WR       = 7;
    localparam int HDR_ADDR_MSB = 4;
    localparam int HDR_ADDR_LSB = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HEADER = 2'd1;
    localparam state_t ST_DATA   = 2'd2;

endpackage

// File: rtl/cd_sync.sv
// N-stage single-bit synchronizer with a selectable reset value so each
// SPI pin can come out of reset at its own idle level.
module cd_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous pin through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cd_spi_csr_bridge.sv
// SPI mode-0 slave that turns a header byte plus data bytes into single-cycle
// CSR read/write strobes. Reads prefetch the next register value at every
// byte boundary so the first MISO bit is ready before the master's next edge.
module cd_spi_csr_bridge
    import cd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_nss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       chip_select,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata
);

    logic       sck_sync;
    logic       nss_sync;
    logic       mosi_sync;
    logic       sck_q;
    logic       sck_rise;
    logic       sck_fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] tx_shift;
    logic       is_write;
    logic [4:0] addr_q;
    logic [7:0] wdata_q;
    logic       read_q;
    logic       write_q;

    logic       byte_done;
    logic       start;
    logic       hdr_done;
    logic       data_done;

    cd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_sck),
        .q       (sck_sync)
    );

    cd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_nss),
        .q       (nss_sync)
    );

    cd_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi_mosi),
        .q       (mosi_sync)
    );

    // One extra stage on the synchronized SCK for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_sync;
        end
    end

    assign sck_rise  = sck_sync & ~sck_q;
    assign sck_fall  = ~sck_sync & sck_q;
    assign rx_next   = {rx_shift[6:0], mosi_sync};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign start     = (state == ST_IDLE) && !nss_sync;
    assign hdr_done  = (state == ST_HEADER) && byte_done && !nss_sync;
    assign data_done = (state == ST_DATA) && byte_done && !nss_sync;

    // Transaction FSM, bit counter and receive shifter; deselect aborts at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
        end else if (nss_sync) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
        end else if (start) begin
            state    <= ST_HEADER;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
        end else if ((state != ST_HEADER) && (state != ST_DATA)) begin
            state    <= ST_IDLE;
        end else if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (hdr_done) begin
                state <= ST_DATA;
            end
        end
    end

    // Capture address and direction from the header; cleared per transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q   <= 5'd0;
            is_write <= 1'b0;
        end else if (start) begin
            addr_q   <= 5'd0;
            is_write <= 1'b0;
        end else if (hdr_done) begin
            addr_q   <= rx_next[HDR_ADDR_MSB:HDR_ADDR_LSB];
            is_write <= rx_next[HDR_WR];
        end
    end

    // Strobes fire one clk after a byte completes; reads also prefetch after the header.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= 8'h00;
        end else begin
            read_q  <= (hdr_done && !rx_next[HDR_WR]) || (data_done && !is_write);
            write_q <= data_done && is_write;
            if (data_done && is_write) begin
                wdata_q <= rx_next;
            end
        end
    end

    // Transmit shifter: load on the read strobe, shift on falls inside a byte only.
    // The fall right after a byte's last rise is skipped so the freshly loaded
    // MSB is not lost before the master samples it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift <= 8'h00;
        end else if (start) begin
            tx_shift <= 8'h00;
        end else if ((state == ST_DATA) && !is_write) begin
            if (read_q) begin
                tx_shift <= csr_readdata;
            end else if (sck_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign chip_select   = ~nss_sync;
    assign spi_miso_oe   = ~nss_sync;
    assign csr_read      = read_q & ~nss_sync;
    assign csr_write     = write_q & ~nss_sync;
    assign csr_address   = addr_q;
    assign csr_writedata = wdata_q;
    assign spi_miso      = ((state == ST_DATA) && !is_write && !nss_sync) ? tx_shift[7] : 1'b0;

endmodule
